// File: rtl/seq_divider64_pkg.sv
// Shared constants for the sequential restoring divider: default sizes and
// the FSM state encoding.
package seq_divider64_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int CNT_W_DEF = 7;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_PREP = 3'd1;
    localparam state_t ST_ITER = 3'd2;
    localparam state_t ST_FIX  = 3'd3;
    localparam state_t ST_DONE = 3'd4;

endpackage

// File: rtl/seq_divider64_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor magnitude, and keep the difference only if it did not borrow.
module seq_divider64_div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH-1:0] low_s;
    logic [WIDTH-1:0] diff_s;
    logic             carry_s;

    // rem_i[WIDTH-1] is the (WIDTH+1)-th bit of the shifted value; when it is
    // set the shifted value already exceeds any WIDTH-bit divisor.
    assign low_s              = {rem_i[WIDTH-2:0], bit_i};
    assign {carry_s, diff_s}  = {1'b0, low_s} + {1'b0, ~dvs_i} + {{WIDTH{1'b0}}, 1'b1};
    assign q_o                = rem_i[WIDTH-1] | carry_s;
    assign rem_o              = q_o ? diff_s : low_s;

endmodule

// File: rtl/seq_divider64.sv
// Multi-cycle signed/unsigned restoring divider: IDLE -> PREP -> WIDTH x ITER
// -> FIX -> DONE, fixed latency regardless of operands.
module seq_divider64
    import seq_divider64_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz_flag,
    output logic             of_flag
);

    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             signed_q, signed_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic             dz_q, dz_d;
    logic             of_q, of_d;

    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dz_flag_q, dz_flag_d;
    logic             of_flag_q, of_flag_d;

    logic [WIDTH-1:0] step_rem_s;
    logic             step_q_s;
    logic             neg_dvd_s;
    logic             neg_dvs_s;

    seq_divider64_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .bit_i (sh_q[WIDTH-1]),
        .dvs_i (mag_q),
        .rem_o (step_rem_s),
        .q_o   (step_q_s)
    );

    assign neg_dvd_s = signed_q & dvd_q[WIDTH-1];
    assign neg_dvs_s = signed_q & mag_q[WIDTH-1];

    // Next-state and datapath computation for every FSM state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        sh_d        = sh_q;
        mag_d       = mag_q;
        rem_d       = rem_q;
        signed_d    = signed_q;
        qsign_d     = qsign_q;
        rsign_d     = rsign_q;
        dz_d        = dz_q;
        of_d        = of_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_flag_d   = dz_flag_q;
        of_flag_d   = of_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvd_d    = dividend;
                    sh_d     = dividend;
                    mag_d    = divisor;
                    signed_d = signed_op;
                    state_d  = ST_PREP;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_PREP: begin
                sh_d    = neg_dvd_s ? neg_w(dvd_q) : dvd_q;
                mag_d   = neg_dvs_s ? neg_w(mag_q) : mag_q;
                qsign_d = neg_dvd_s ^ neg_dvs_s;
                rsign_d = neg_dvd_s;
                dz_d    = (mag_q == {WIDTH{1'b0}});
                of_d    = signed_q & (dvd_q == MIN_NEG) & (mag_q == {WIDTH{1'b1}});
                rem_d   = {WIDTH{1'b0}};
                cnt_d   = LAST_C;
                state_d = ST_ITER;
            end
            ST_ITER: begin
                // sh_q shifts dividend bits out of the top and quotient bits in at the bottom.
                rem_d = step_rem_s;
                sh_d  = {sh_q[WIDTH-2:0], step_q_s};
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d   = cnt_q - ONE_C;
                end
            end
            ST_FIX: begin
                if (dz_q) begin
                    quotient_d  = {WIDTH{1'b1}};
                    remainder_d = dvd_q;
                end else if (of_q) begin
                    quotient_d  = dvd_q;
                    remainder_d = {WIDTH{1'b0}};
                end else begin
                    quotient_d  = qsign_q ? neg_w(sh_q) : sh_q;
                    remainder_d = rsign_q ? neg_w(rem_q) : rem_q;
                end
                dz_flag_d = dz_q;
                of_flag_d = of_q;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // Control state: FSM, iteration counter and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // Working datapath registers for the division in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q    <= {WIDTH{1'b0}};
            sh_q     <= {WIDTH{1'b0}};
            mag_q    <= {WIDTH{1'b0}};
            rem_q    <= {WIDTH{1'b0}};
            signed_q <= 1'b0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            dz_q     <= 1'b0;
            of_q     <= 1'b0;
        end else begin
            dvd_q    <= dvd_d;
            sh_q     <= sh_d;
            mag_q    <= mag_d;
            rem_q    <= rem_d;
            signed_q <= signed_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
            dz_q     <= dz_d;
            of_q     <= of_d;
        end
    end

    // Result registers, written only in FIX and held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            dz_flag_q   <= 1'b0;
            of_flag_q   <= 1'b0;
        end else begin
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_flag_q   <= dz_flag_d;
            of_flag_q   <= of_flag_d;
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dz_flag   = dz_flag_q;
    assign of_flag   = of_flag_q;

endmodule

// File: tb/tb_seq_divider64.sv
// Scoreboard bench for seq_divider64: a driver pushes reference results at
// each accepted start, a monitor pops and compares on every done pulse.
module tb_seq_divider64;

    localparam int LAT = 66;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        ready;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        dz_flag;
    logic        of_flag;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        dz;
        logic        of;
        int          edge_n;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   edge_cnt = 0;

    seq_divider64 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz_flag   (dz_flag),
        .of_flag   (of_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: truncating division with the divide-by-zero and overflow rules.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic s, input int accept_edge);
        exp_t x;
        longint sa;
        longint sb;
        x.edge_n = accept_edge + LAT;
        x.dz = 1'b0;
        x.of = 1'b0;
        if (b == 64'd0) begin
            x.dz = 1'b1;
            x.q  = 64'hFFFF_FFFF_FFFF_FFFF;
            x.r  = a;
        end else if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
            x.of = 1'b1;
            x.q  = a;
            x.r  = 64'd0;
        end else if (s) begin
            sa  = $signed(a);
            sb  = $signed(b);
            x.q = 64'(sa / sb);
            x.r = 64'(sa % sb);
        end else begin
            x.q = a / b;
            x.r = a % b;
        end
        return x;
    endfunction

    // Monitor: compare each done pulse with the scoreboard, check holding behaviour.
    logic [63:0] last_q = 64'd0;
    logic [63:0] last_r = 64'd0;
    logic [1:0]  last_f = 2'd0;
    logic        prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_q    = 64'd0;
            last_r    = 64'd0;
            last_f    = 2'd0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                chk("done_width", {63'd0, prev_done}, 64'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected none (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("dz_flag", {63'd0, dz_flag}, {63'd0, e.dz});
                    chk("of_flag", {63'd0, of_flag}, {63'd0, e.of});
                    chk("latency_edge", 64'(edge_cnt), 64'(e.edge_n));
                end
                last_q = quotient;
                last_r = remainder;
                last_f = {dz_flag, of_flag};
            end else begin
                chk("hold_quotient", quotient, last_q);
                chk("hold_remainder", remainder, last_r);
                chk("hold_flags", {62'd0, dz_flag, of_flag}, {62'd0, last_f});
                if (exp_q.size() != 0 && edge_cnt > exp_q[0].edge_n) begin
                    checks++;
                    errors++;
                    $display("FAIL done_timeout: got no done by edge %0d expected at %0d",
                             edge_cnt, exp_q[0].edge_n);
                    void'(exp_q.pop_front());
                end
            end
            prev_done = done;
        end
    end

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 expected 1 within 200 cycles");
        end else begin
            dividend  = a;
            divisor   = b;
            signed_op = s;
            start     = 1'b1;
            exp_q.push_back(model(a, b, s, edge_cnt + 1));
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        logic        s;
        int          acc;
        int          last_acc;
        int          guard;
        int          sel;

        rst       = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = 64'd0;
        divisor   = 64'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", {63'd0, ready}, 64'd1);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_quotient", quotient, 64'd0);
        chk("reset_remainder", remainder, 64'd0);
        chk("reset_flags", {62'd0, dz_flag, of_flag}, 64'd0);

        // Normal 100/7, then abort a second one mid-iteration with reset.
        issue(64'd100, 64'd7, 1'b0);
        drain();
        issue(64'd100, 64'd7, 1'b0);
        repeat (10) @(negedge clk);
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", {63'd0, ready}, 64'd1);
        chk("abort_quotient", quotient, 64'd0);
        chk("abort_remainder", remainder, 64'd0);
        chk("abort_flags", {62'd0, dz_flag, of_flag}, 64'd0);
        repeat (80) @(negedge clk);

        // Directed cases.
        issue(64'd100, 64'd7, 1'b0);
        issue(-64'sd100, 64'd7, 1'b1);
        issue(64'd100, -64'sd7, 1'b1);
        issue(-64'sd100, -64'sd7, 1'b1);
        issue(64'h1234, 64'd0, 1'b0);
        issue(64'h1234, 64'd0, 1'b1);
        issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0);
        issue(64'h8000_0000_0000_0000, 64'd1, 1'b1);
        issue(64'd5, 64'd9, 1'b1);
        drain();

        // Randomised operands with biased divisor classes.
        for (int i = 0; i < 24; i++) begin
            a   = {$urandom, $urandom} >> $urandom_range(0, 40);
            if ($urandom_range(0, 1) == 1) a = -a;
            sel = $urandom_range(0, 5);
            case (sel)
                0:       b = 64'd0;
                1:       b = 64'hFFFF_FFFF_FFFF_FFFF;
                2:       b = 64'($urandom_range(1, 1000));
                3:       b = -64'($urandom_range(1, 1000));
                default: b = {$urandom, $urandom} >> $urandom_range(0, 63);
            endcase
            s = 1'($urandom_range(0, 1));
            issue(a, b, s);
        end
        drain();

        // start held high with changing operands: only ready cycles are accepted.
        acc      = 0;
        last_acc = -1;
        guard    = 0;
        while (acc < 3 && guard < 400) begin
            @(negedge clk);
            guard++;
            a         = {$urandom, $urandom};
            b         = {$urandom, $urandom} >> $urandom_range(0, 60);
            s         = 1'($urandom_range(0, 1));
            dividend  = a;
            divisor   = b;
            signed_op = s;
            start     = 1'b1;
            if (ready) begin
                exp_q.push_back(model(a, b, s, edge_cnt + 1));
                if (last_acc >= 0) chk("accept_spacing", 64'(edge_cnt + 1 - last_acc), 64'd68);
                last_acc = edge_cnt + 1;
                acc++;
            end
        end
        if (acc < 3) begin
            checks++;
            errors++;
            $display("FAIL handshake_accepts: got %0d expected 3", acc);
        end
        @(negedge clk);
        start = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
